// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Summary  : Shared Funct3 encodings, FSM state enum and access helpers.
// Options  : MISALIGN_TRAP_EN - adds the misaligned-access check.
// Revision : 1.0
// ============================================================================
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  function automatic logic funct3_unsupported(input logic [2:0] funct3, input logic is_store);
    logic bad;
    case (funct3)
      F3_B, F3_H, F3_W: bad = 1'b0;
      F3_BU, F3_HU:     bad = is_store;
      default:          bad = 1'b1;
    endcase
    return bad;
  endfunction

`ifdef MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic mis;
    case (funct3[1:0])
      2'b01:   mis = addr_lo[0];
      2'b10:   mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction
`endif

  // Half/word accesses drop the low address bits they cannot use.
  function automatic logic [1:0] align_lo(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic [1:0] lo;
    case (funct3[1:0])
      2'b00:   lo = addr_lo;
      2'b01:   lo = {addr_lo[1], 1'b0};
      default: lo = 2'b00;
    endcase
    return lo;
  endfunction

  function automatic logic [3:0] store_strobe(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (funct3[1:0])
      2'b00:   strb = 4'b0001 << addr_lo;
      2'b01:   strb = 4'b0011 << {addr_lo[1], 1'b0};
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
// Module   : load_extend
// Summary  : Selects the load byte/half lane and sign- or zero-extends it.
// Revision : 1.0
// ============================================================================
module load_extend
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] bus_rdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = bus_rdata[7:0];
      2'd1:    byte_sel = bus_rdata[15:8];
      2'd2:    byte_sel = bus_rdata[23:16];
      default: byte_sel = bus_rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_data = {24'b0, byte_sel};
      F3_HU:   load_data = {16'b0, half_sel};
      default: load_data = bus_rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_lsu
// Summary  : MEM-stage load/store unit bridging EX to a valid/ready data bus.
// Options  : MISALIGN_TRAP_EN - reject misaligned half/word accesses.
// Revision : 1.0
// ============================================================================
module mem_stage_lsu
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemReq,
  input  logic              MemWrite,
  input  logic [2:0]        Funct3,
  input  logic [ADDR_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] WriteData,
  output logic              Stall,
  output logic [DATA_W-1:0] ReadData,
  output logic              Done,
  output logic              AccessErr,
  output logic              BusValid,
  output logic              BusWe,
  output logic [ADDR_W-1:0] BusAddr,
  output logic [31:0]       BusWData,
  output logic [3:0]        BusWStrb,
  input  logic              BusReady,
  input  logic              BusRValid,
  input  logic [31:0]       BusRData
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic              reject;
  logic [31:0]       load_val;

`ifdef MISALIGN_TRAP_EN
  assign reject = funct3_unsupported(Funct3, MemWrite) || misaligned(Funct3, ALUResult[1:0]);
`else
  assign reject = funct3_unsupported(Funct3, MemWrite);
`endif

  load_extend u_load_extend (
    .funct3    (funct3_q),
    .addr_lo   (addr_q[1:0]),
    .bus_rdata (BusRData),
    .load_data (load_val)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    funct3_d = funct3_q;
    we_d     = we_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (MemReq) begin
          addr_d   = {ALUResult[ADDR_W-1:2], align_lo(Funct3, ALUResult[1:0])};
          wdata_d  = WriteData;
          funct3_d = Funct3;
          we_d     = MemWrite;
          err_d    = reject;
          if (reject) begin
            rdata_d = '0;
            state_d = ST_DONE;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (BusReady) begin
          if (we_q) begin
            state_d = ST_DONE;
          end else if (BusRValid) begin
            rdata_d = load_val;
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT_R;
          end
        end
      end
      ST_WAIT_R: begin
        if (BusRValid) begin
          rdata_d = load_val;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      funct3_q <= 3'b000;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
      err_q    <= err_d;
    end
  end

  // Narrow stores are replicated so any lane the strobe selects carries the data.
  always_comb begin
    case (funct3_q[1:0])
      2'b00:   BusWData = {4{wdata_q[7:0]}};
      2'b01:   BusWData = {2{wdata_q[15:0]}};
      default: BusWData = wdata_q[31:0];
    endcase
  end

  assign BusValid  = (state_q == ST_REQ);
  assign BusWe     = BusValid && we_q;
  assign BusAddr   = {addr_q[ADDR_W-1:2], 2'b00};
  assign BusWStrb  = BusWe ? store_strobe(funct3_q, addr_q[1:0]) : 4'b0000;
  assign Done      = (state_q == ST_DONE);
  assign AccessErr = Done && err_q;
  assign ReadData  = rdata_q;
  assign Stall     = (state_q != ST_DONE) && ((state_q != ST_IDLE) || MemReq);

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_lsu
// Summary  : Scoreboard bench for mem_stage_lsu with a bus memory responder.
// Options  : MISALIGN_TRAP_EN - expects misaligned half/word accesses rejected.
// Revision : 1.0
// ============================================================================
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReq, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] ALUResult, WriteData;
  logic        Stall, Done, AccessErr;
  logic [31:0] ReadData;
  logic        BusValid, BusWe, BusReady, BusRValid;
  logic [31:0] BusAddr, BusWData, BusRData;
  logic [3:0]  BusWStrb;

  mem_stage_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .MemReq(MemReq), .MemWrite(MemWrite), .Funct3(Funct3),
    .ALUResult(ALUResult), .WriteData(WriteData), .Stall(Stall), .ReadData(ReadData),
    .Done(Done), .AccessErr(AccessErr), .BusValid(BusValid), .BusWe(BusWe),
    .BusAddr(BusAddr), .BusWData(BusWData), .BusWStrb(BusWStrb), .BusReady(BusReady),
    .BusRValid(BusRValid), .BusRData(BusRData)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; logic [3:0] strb; } bus_exp_t;
  typedef struct { logic err; logic chk_rd; logic [31:0] rd; } done_exp_t;

  bus_exp_t    bus_q[$];
  done_exp_t   done_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_mem[int];
  logic [31:0] bus_mem[int];
  int          resp_auto = 1, ready_always = 0, hold_low = 0, rv_delay = -1;
  logic        hold_valid = 1'b0;
  logic [31:0] hold_val = 32'h0;

  function automatic logic [31:0] init_word(input int idx);
    return (32'(idx) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] model_rd(input int idx);
    return model_mem.exists(idx) ? model_mem[idx] : init_word(idx);
  endfunction

  function automatic logic [31:0] bus_rd(input int idx);
    return bus_mem.exists(idx) ? bus_mem[idx] : init_word(idx);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] word);
    model_mem[int'(addr >> 2)] = word;
    bus_mem[int'(addr >> 2)]   = word;
  endtask

  // Reference model: byte-lane view of a little-endian word memory.
  task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] data, input int exp_lat);
    int          size, off, lat;
    logic        rej, done_seen;
    bus_exp_t    be;
    done_exp_t   de;
    logic [31:0] w;
    logic [63:0] v;
    @(posedge clk); #1;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    rej  = (f3 == 3'b011) || (f3 >= 3'b110) || (we && f3[2]);
`ifdef MISALIGN_TRAP_EN
    if (!rej && (addr % size) != 0) rej = 1'b1;
`endif
    off = int'(addr % 4);
    off = off - (off % size);
    de.err = rej; de.chk_rd = rej || !we; de.rd = 32'h0;
    if (!rej) begin
      be.addr = addr - (addr % 4); be.we = we; be.wdata = 32'h0; be.strb = 4'h0;
      w = model_rd(int'(addr >> 2));
      for (int i = 0; i < 4; i++) begin
        if (we) begin
          be.wdata[8*i +: 8] = data[8*(i % size) +: 8];
          if (i >= off && i < off + size) begin
            be.strb[i] = 1'b1;
            w[8*i +: 8] = data[8*(i - off) +: 8];
          end
        end
      end
      if (we) model_mem[int'(addr >> 2)] = w;
      else begin
        v = {32'h0, w} >> (8 * off);
        if (size < 4) begin
          v = v & ((64'd1 << (8 * size)) - 64'd1);
          if (!f3[2] && v >= (64'd1 << (8 * size - 1))) v = v - (64'd1 << (8 * size));
        end
        de.rd = v[31:0];
      end
      bus_q.push_back(be);
    end
    done_q.push_back(de);

    MemReq = 1'b1; MemWrite = we; Funct3 = f3; ALUResult = addr; WriteData = data;
    @(negedge clk);
    chk("stall_on_request", Stall, 1);
    lat = 0; done_seen = 1'b0;
    while (!done_seen && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (Done) begin
        done_seen = 1'b1;
        MemReq = 1'b0;
      end else begin
        MemReq = 1'($urandom_range(0, 1)); MemWrite = 1'($urandom_range(0, 1));
        Funct3 = 3'($urandom); ALUResult = $urandom; WriteData = $urandom;
      end
      if (lat == 1 && exp_lat >= 0 && !rej) chk("busvalid_cycle1", BusValid, 1);
      @(negedge clk);
      chk("stall_until_done", Stall, !done_seen);
    end
    MemReq = 1'b0;
    if (!done_seen) chk("txn_done_timeout", done_seen, 1);
    if (exp_lat >= 0) chk("latency", lat, exp_lat);
  endtask

  initial begin : responder
    int          pend_cnt, valid_cycles, d, pend_idx;
    logic        pend;
    logic [31:0] w;
    pend = 1'b0; pend_cnt = 0; valid_cycles = 0; pend_idx = 0;
    BusReady = 1'b0; BusRValid = 1'b0; BusRData = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (reset || !resp_auto) begin
        pend = 1'b0;
        valid_cycles = 0;
      end
      if (resp_auto) begin
        BusRValid = 1'b0; BusRData = $urandom;
        if (pend) begin
          if (pend_cnt == 0) begin
            BusRValid = 1'b1; BusRData = bus_rd(pend_idx); pend = 1'b0;
          end else pend_cnt--;
        end
        if (BusValid) begin
          if (valid_cycles < hold_low) BusReady = 1'b0;
          else BusReady = ready_always ? 1'b1 : 1'($urandom_range(0, 1));
          valid_cycles++;
          if (BusReady && !BusWe) begin
            d = (rv_delay < 0) ? int'($urandom_range(0, 3)) : rv_delay;
            if (d == 0) begin
              BusRValid = 1'b1; BusRData = bus_rd(int'(BusAddr >> 2));
            end else begin
              pend = 1'b1; pend_cnt = d - 1; pend_idx = int'(BusAddr >> 2);
            end
          end
        end else begin
          valid_cycles = 0;
          BusReady = 1'($urandom_range(0, 1));
        end
      end
      @(negedge clk);
      if (!reset && BusValid && BusReady && BusWe) begin
        w = bus_rd(int'(BusAddr >> 2));
        for (int i = 0; i < 4; i++) if (BusWStrb[i]) w[8*i +: 8] = BusWData[8*i +: 8];
        bus_mem[int'(BusAddr >> 2)] = w;
      end
    end
  end

  initial begin : monitor
    bus_exp_t  be;
    done_exp_t de;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (BusValid) begin
          if (bus_q.size() == 0) chk("unexpected_busvalid", BusValid, 0);
          else begin
            be = bus_q[0];
            chk("bus_addr", BusAddr, be.addr);
            chk("bus_we", BusWe, be.we);
            chk("bus_wstrb", BusWStrb, be.strb);
            if (be.we) chk("bus_wdata", BusWData, be.wdata);
            if (BusReady) be = bus_q.pop_front();
          end
        end
        if (Done) begin
          if (done_q.size() == 0) chk("unexpected_done", Done, 0);
          else begin
            de = done_q.pop_front();
            chk("access_err", AccessErr, de.err);
            if (de.chk_rd) begin
              chk("read_data", ReadData, de.rd);
              hold_valid = 1'b1; hold_val = de.rd;
            end else hold_valid = 1'b0;
          end
        end else begin
          chk("access_err_without_done", AccessErr, 0);
          if (hold_valid) chk("read_data_hold", ReadData, hold_val);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin : main
    reset = 1'b1; MemReq = 1'b0; MemWrite = 1'b0; Funct3 = 3'b000;
    ALUResult = 32'h0; WriteData = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_busvalid", BusValid, 0);
    chk("rst_done", Done, 0);
    chk("rst_accesserr", AccessErr, 0);
    chk("rst_readdata", ReadData, 0);
    chk("rst_wstrb", BusWStrb, 0);
    chk("rst_stall_idle", Stall, 0);
    MemReq = 1'b1; #1;
    chk("rst_stall_memreq", Stall, 1);
    MemReq = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; hold_valid = 1'b1; hold_val = 32'h0;

    ready_always = 1; rv_delay = 0;
    do_txn(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 2);
    preload(32'h100, 32'h80FFFF00);
    rv_delay = 2;
    do_txn(1'b0, 3'b000, 32'h103, 32'h0, 4);
    preload(32'h100, 32'hBEEF1234);
    rv_delay = 0;
    do_txn(1'b0, 3'b101, 32'h102, 32'h0, 2);
    rv_delay = 1;
    do_txn(1'b0, 3'b001, 32'h102, 32'h0, 3);
    do_txn(1'b1, 3'b000, 32'h101, 32'h000000AB, 2);
    do_txn(1'b0, 3'b010, 32'h100, 32'h0, 3);
    hold_low = 5;
    do_txn(1'b1, 3'b001, 32'h142, 32'h1234CAFE, 7);
    do_txn(1'b0, 3'b010, 32'h140, 32'h0, 8);
    hold_low = 0;
`ifdef MISALIGN_TRAP_EN
    do_txn(1'b0, 3'b010, 32'h102, 32'h0, 1);
`else
    do_txn(1'b0, 3'b010, 32'h102, 32'h0, 3);
`endif
    do_txn(1'b0, 3'b011, 32'h104, 32'h0, 1);
    do_txn(1'b1, 3'b100, 32'h108, 32'h55, 1);
    do_txn(1'b0, 3'b111, 32'h10C, 32'h0, 1);

    // Reset while a load waits for data; the late response must be dropped.
    resp_auto = 0;
    preload(32'h200, 32'h11223344);
    @(posedge clk); #1;
    MemReq = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; ALUResult = 32'h200;
    BusReady = 1'b0; BusRValid = 1'b0;
    bus_q.push_back('{addr: 32'h200, we: 1'b0, wdata: 32'h0, strb: 4'h0});
    @(posedge clk); #1;
    MemReq = 1'b0; BusReady = 1'b1;
    @(posedge clk); #1;
    BusReady = 1'b0;
    chk("wait_r_busvalid", BusValid, 0);
    chk("wait_r_stall", Stall, 1);
    reset = 1'b1;
    bus_q.delete(); done_q.delete();
    #1;
    chk("midrst_busvalid", BusValid, 0);
    chk("midrst_done", Done, 0);
    chk("midrst_stall", Stall, 0);
    chk("midrst_readdata", ReadData, 0);
    chk("midrst_wstrb", BusWStrb, 0);
    @(posedge clk); #1;
    reset = 1'b0; hold_valid = 1'b1; hold_val = 32'h0;
    BusRValid = 1'b1; BusRData = 32'hCAFEF00D;
    @(posedge clk); #1;
    BusRValid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_no_done", Done, 0);
      chk("post_rst_no_busvalid", BusValid, 0);
    end
    resp_auto = 1;
    rv_delay = 1;
    do_txn(1'b0, 3'b010, 32'h200, 32'h0, 3);

    ready_always = 0; rv_delay = -1;
    for (int n = 0; n < 200; n++) begin
      do_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             32'h100 + 32'($urandom_range(0, 63)), $urandom, -1);
    end

    repeat (3) @(negedge clk);
    chk("bus_queue_drained", bus_q.size(), 0);
    chk("done_queue_drained", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
